// File: rtl/instr_fetch_unit_pkg.sv
// Package: instr_fetch_unit_pkg
// Purpose: shared definitions for the IF stage and its neighbours. It holds the
//          word/immediate/jump-field widths, the NOP encoding, the opcode/funct
//          codes for the J-type and JR redirects, the next-PC select encoding,
//          the IF/ID latch layout and the PC target helpers.
// Ports:   none (package)
package instr_fetch_unit_pkg;

  localparam int WORD_W  = 32;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OPCODE_J   = 6'h02;
  localparam logic [5:0] OPCODE_JAL = 6'h03;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  // Next-PC source, in decreasing priority below reset.
  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_JR     = 3'd1,
    PC_JUMP   = 3'd2,
    PC_BRANCH = 3'd3,
    PC_SEQ    = 3'd4
  } pc_sel_e;

  // IF/ID latch contents as seen by instr_splitter.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] instr;
    logic              valid;
    logic              fault;
  } ifid_t;

  // Signed word offset of a branch, turned into a byte displacement.
  function automatic logic [WORD_W-1:0] branch_disp(input logic [IMM_W-1:0] off);
    return {{(WORD_W-IMM_W-2){off[IMM_W-1]}}, off, 2'b00};
  endfunction

  // J/JAL target: keep the 256 MB region of the link address.
  function automatic logic [WORD_W-1:0] jump_addr(input logic [3:0]         region,
                                                  input logic [JADDR_W-1:0] target);
    return {region, target, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Interface: instr_fetch_unit_if
// Purpose: bundles the redirect/hold controls going into the IF stage and the
//          IF/ID latch contents coming out of it.
// Signals:
//   stall, flush, branch_taken, branch_offset[15:0], jump, jump_target[25:0],
//   jump_reg, reg_target[31:0]                  -> into the fetch unit
//   pc_out[31:0], pc_plus4[31:0], instruction[31:0], instr_valid, addr_fault
//                                               <- from the fetch unit
// Modports: slave = fetch unit, master = pipeline control / decode side.
//
// Transfer rule: every clock edge without stall moves one fetch into the latch;
// instr_valid qualifies the latch contents (0 after reset or flush). stall acts
// as the hold signal: while it is high the latch and PC do not move and any
// redirect presented is ignored, so the requester keeps it asserted until stall
// drops. flush is taken on the edge it is sampled and needs no hold.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
;
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [IMM_W-1:0]   branch_offset;
  logic               jump;
  logic [JADDR_W-1:0] jump_target;
  logic               jump_reg;
  logic [WORD_W-1:0]  reg_target;
  logic [WORD_W-1:0]  pc_out;
  logic [WORD_W-1:0]  pc_plus4;
  logic [WORD_W-1:0]  instruction;
  logic               instr_valid;
  logic               addr_fault;

  modport slave (
    input  stall, flush, branch_taken, branch_offset, jump, jump_target,
           jump_reg, reg_target,
    output pc_out, pc_plus4, instruction, instr_valid, addr_fault
  );

  modport master (
    output stall, flush, branch_taken, branch_offset, jump, jump_target,
           jump_reg, reg_target,
    input  pc_out, pc_plus4, instruction, instr_valid, addr_fault
  );

endinterface

// File: rtl/instr_fetch_unit_rom.sv
// Module: instr_fetch_unit_rom
// Purpose: MEM_DEPTH x 32 instruction ROM with a combinational read and an
//          out-of-range flag. The image is supplied through MEM_INIT (word i at
//          bits [32*i +: 32]) so the ROM needs no load-time file access.
// Ports:
//   word_addr[29:0]  in   word address (byte PC >> 2)
//   data[31:0]       out  ROM word, NOP when out of range
//   out_of_range     out  word_addr >= MEM_DEPTH
module instr_fetch_unit_rom
  import instr_fetch_unit_pkg::*;
#(
  parameter int                          MEM_DEPTH = 256,
  parameter logic [MEM_DEPTH*WORD_W-1:0] MEM_INIT  = '0
) (
  input  logic [WORD_W-3:0] word_addr,
  output logic [WORD_W-1:0] data,
  output logic              out_of_range
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_word
    assign mem[i] = MEM_INIT[i*WORD_W +: WORD_W];
  end

  // Compare the full word address so high PCs never alias onto low words.
  assign out_of_range = (word_addr >= (WORD_W-2)'(MEM_DEPTH));
  assign data         = out_of_range ? NOP_INSTR : mem[word_addr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Module: instr_fetch_unit
// Purpose: IF stage of the 32-bit MIPS core. Holds the PC, reads the instruction
//          ROM and registers {pc, pc+4, instruction, valid, fault} into the IF/ID
//          latch feeding instr_splitter. Next PC is chosen from sequential,
//          PC-relative branch, J-type and JR targets; stall holds, flush kills.
// Parameters: RESET_PC (word aligned), MEM_DEPTH (ROM words), MEM_INIT (ROM image)
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset, overrides everything
//   ifu    instr_fetch_unit_if.slave (controls in, IF/ID latch out)
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0]           RESET_PC  = 32'h0000_0000,
  parameter int                          MEM_DEPTH = 256,
  parameter logic [MEM_DEPTH*WORD_W-1:0] MEM_INIT  = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.slave  ifu
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] pc_seq;
  // Set by a JR to a misaligned target; flags the fetch made from that target.
  logic              misalign_q;
  logic              misalign_next;
  pc_sel_e           pc_sel;
  ifid_t             ifid_q;
  ifid_t             ifid_d;
  logic [WORD_W-1:0] rom_data;
  logic              rom_oor;

  instr_fetch_unit_rom #(
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_INIT  (MEM_INIT)
  ) u_rom (
    .word_addr    (pc_q[WORD_W-1:2]),
    .data         (rom_data),
    .out_of_range (rom_oor)
  );

  // Wraps modulo 2^32 by construction.
  assign pc_seq = pc_q + 32'd4;

  always_comb begin
    pc_sel = PC_SEQ;
    if (ifu.stall)             pc_sel = PC_HOLD;
    else if (ifu.jump_reg)     pc_sel = PC_JR;
    else if (ifu.jump)         pc_sel = PC_JUMP;
    else if (ifu.branch_taken) pc_sel = PC_BRANCH;
  end

  always_comb begin
    pc_next       = pc_seq;
    misalign_next = 1'b0;
    case (pc_sel)
      PC_HOLD: begin
        pc_next       = pc_q;
        misalign_next = misalign_q;
      end
      PC_JR: begin
        pc_next       = {ifu.reg_target[WORD_W-1:2], 2'b00};
        misalign_next = |ifu.reg_target[1:0];
      end
      // The J-type region comes from the link value of the instruction in ID.
      PC_JUMP:   pc_next = jump_addr(ifid_q.pc_plus4[WORD_W-1:WORD_W-4], ifu.jump_target);
      PC_BRANCH: pc_next = pc_seq + branch_disp(ifu.branch_offset);
      default:   ;
    endcase
  end

  // Flush overrides stall for the instruction/valid/fault fields only; the PC
  // fields follow stall so a flushed-while-stalled slot keeps its address.
  always_comb begin
    ifid_d = ifid_q;
    if (!ifu.stall) begin
      ifid_d.pc       = pc_q;
      ifid_d.pc_plus4 = pc_seq;
      ifid_d.instr    = rom_data;
      ifid_d.valid    = 1'b1;
      ifid_d.fault    = rom_oor | misalign_q;
    end
    if (ifu.flush) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
      ifid_d.fault = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      ifid_q     <= '0;
    end else begin
      pc_q       <= pc_next;
      misalign_q <= misalign_next;
      ifid_q     <= ifid_d;
    end
  end

  assign ifu.pc_out      = ifid_q.pc;
  assign ifu.pc_plus4    = ifid_q.pc_plus4;
  assign ifu.instruction = ifid_q.instr;
  assign ifu.instr_valid = ifid_q.valid;
  assign ifu.addr_fault  = ifid_q.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus a short random run, with a
// reference model of the fetch stage feeding an expected-value queue.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 64;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          W = 98;

  function automatic logic [31:0] rom_word(input logic [31:0] i);
    if (i == 32'd0) return 32'h2008_0005;
    return {8'hA5, i[7:0], i[15:0] ^ 16'h5A3C};
  endfunction

  function automatic logic [DEPTH*32-1:0] make_image();
    logic [DEPTH*32-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) img[i*32 +: 32] = rom_word(32'(i));
    return img;
  endfunction

  localparam logic [DEPTH*32-1:0] IMAGE = make_image();

  logic clk;
  logic reset;
  instr_fetch_unit_if ifu ();

  instr_fetch_unit #(
    .RESET_PC  (RST_PC),
    .MEM_DEPTH (DEPTH),
    .MEM_INIT  (IMAGE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ifu   (ifu.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_out, m_p4, m_ins;
  logic        m_mis, m_val, m_flt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctrl();
    ifu.stall = 1'b0; ifu.flush = 1'b0; ifu.branch_taken = 1'b0;
    ifu.branch_offset = 16'h0; ifu.jump = 1'b0; ifu.jump_target = 26'h0;
    ifu.jump_reg = 1'b0; ifu.reg_target = 32'h0;
  endtask

  // One clock edge: model the edge, queue the expectation, then compare.
  task automatic tick(input string tag);
    logic [31:0] nxt;
    logic        nmis;
    logic [31:0] wa;
    logic [W-1:0] e;
    if (reset) begin
      m_pc = RST_PC; m_mis = 1'b0;
      m_out = 32'h0; m_p4 = 32'h0; m_ins = 32'h0; m_val = 1'b0; m_flt = 1'b0;
    end else begin
      nxt = m_pc; nmis = m_mis;
      if (!ifu.stall) begin
        nmis = 1'b0;
        if (ifu.jump_reg) begin
          nxt = {ifu.reg_target[31:2], 2'b00};
          nmis = |ifu.reg_target[1:0];
        end else if (ifu.jump) nxt = {m_p4[31:28], ifu.jump_target, 2'b00};
        else if (ifu.branch_taken)
          nxt = m_pc + 32'd4 + {{14{ifu.branch_offset[15]}}, ifu.branch_offset, 2'b00};
        else nxt = m_pc + 32'd4;
      end
      if (ifu.flush) begin
        m_ins = 32'h0; m_val = 1'b0; m_flt = 1'b0;
      end else if (!ifu.stall) begin
        wa = {2'b00, m_pc[31:2]};
        m_ins = (wa < 32'(DEPTH)) ? rom_word(wa) : 32'h0;
        m_val = 1'b1;
        m_flt = (wa >= 32'(DEPTH)) | m_mis;
      end
      if (!ifu.stall) begin
        m_out = m_pc; m_p4 = m_pc + 32'd4;
      end
      m_pc = nxt; m_mis = nmis;
    end
    exp_q.push_back({m_out, m_p4, m_ins, m_val, m_flt});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc_out"},   ifu.pc_out,      e[97:66]);
    chk({tag, ".pc_plus4"}, ifu.pc_plus4,    e[65:34]);
    chk({tag, ".instr"},    ifu.instruction, e[33:2]);
    chk({tag, ".valid"},    32'(ifu.instr_valid), 32'(e[1]));
    chk({tag, ".fault"},    32'(ifu.addr_fault),  32'(e[0]));
  endtask

  initial begin
    reset = 1'b1;
    clear_ctrl();
    m_pc = RST_PC; m_mis = 1'b0; m_out = '0; m_p4 = '0; m_ins = '0; m_val = 1'b0; m_flt = 1'b0;

    // reset state
    tick("reset0");
    tick("reset1");
    chk("reset_valid", 32'(ifu.instr_valid), 32'h0);
    chk("reset_instr", ifu.instruction, 32'h0);

    // release: first valid fetch on first edge
    reset = 1'b0;
    tick("edge1");
    chk("edge1_pc", ifu.pc_out, 32'h0);
    chk("edge1_instr", ifu.instruction, 32'h2008_0005);
    chk("edge1_valid", 32'(ifu.instr_valid), 32'h1);
    tick("edge2");
    chk("edge2_pc", ifu.pc_out, 32'h4);
    tick("edge3");
    tick("edge4");
    chk("edge4_pc", ifu.pc_out, 32'hC);
    chk("edge4_p4", ifu.pc_plus4, 32'h10);

    // JR to 8, then branch back by 2 words with a flush
    ifu.jump_reg = 1'b1; ifu.reg_target = 32'h8;
    tick("jr8");
    clear_ctrl();
    ifu.branch_taken = 1'b1; ifu.branch_offset = 16'hFFFE; ifu.flush = 1'b1;
    tick("br_back");
    chk("br_back_flush_valid", 32'(ifu.instr_valid), 32'h0);
    clear_ctrl();
    tick("br_back_tgt");
    chk("br_back_pc", ifu.pc_out, 32'h4);

    // pc=8 now, forward branch by 3 words
    ifu.branch_taken = 1'b1; ifu.branch_offset = 16'h0003;
    tick("br_fwd");
    clear_ctrl();
    tick("br_fwd_tgt");
    chk("br_fwd_pc", ifu.pc_out, 32'h18);

    // J with pc_plus4 = 0x1C -> target 0x40
    ifu.jump = 1'b1; ifu.jump_target = 26'h10;
    tick("jump");
    clear_ctrl();
    tick("jump_tgt");
    chk("jump_pc", ifu.pc_out, 32'h40);

    // misaligned JR target
    ifu.jump_reg = 1'b1; ifu.reg_target = 32'h22;
    tick("jr_mis");
    clear_ctrl();
    tick("jr_mis_tgt");
    chk("jr_mis_pc", ifu.pc_out, 32'h20);
    chk("jr_mis_fault", 32'(ifu.addr_fault), 32'h1);
    tick("jr_mis_after");
    chk("jr_mis_clear", 32'(ifu.addr_fault), 32'h0);

    // priority: jr beats jump beats branch
    ifu.jump_reg = 1'b1; ifu.reg_target = 32'h30;
    ifu.jump = 1'b1; ifu.jump_target = 26'h3F;
    ifu.branch_taken = 1'b1; ifu.branch_offset = 16'h0010;
    tick("prio");
    clear_ctrl();
    tick("prio_tgt");
    chk("prio_pc", ifu.pc_out, 32'h30);

    // stall 3 cycles with a redirect that must be ignored
    ifu.stall = 1'b1; ifu.branch_taken = 1'b1; ifu.branch_offset = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_pc", ifu.pc_out, 32'h30);
      chk("stall_instr", ifu.instruction, rom_word(32'd12));
    end
    ifu.flush = 1'b1;
    tick("stall_flush");
    chk("stall_flush_instr", ifu.instruction, 32'h0);
    chk("stall_flush_valid", 32'(ifu.instr_valid), 32'h0);
    chk("stall_flush_pc", ifu.pc_out, 32'h30);
    clear_ctrl();
    tick("unstall");
    chk("unstall_pc", ifu.pc_out, 32'h34);

    // out of range fetch
    ifu.jump_reg = 1'b1; ifu.reg_target = 32'(4 * DEPTH);
    tick("jr_oor");
    clear_ctrl();
    tick("oor");
    chk("oor_pc", ifu.pc_out, 32'(4 * DEPTH));
    chk("oor_instr", ifu.instruction, 32'h0);
    chk("oor_fault", 32'(ifu.addr_fault), 32'h1);
    chk("oor_valid", 32'(ifu.instr_valid), 32'h1);
    tick("oor_next");

    // PC wrap at the top of the address space
    ifu.jump_reg = 1'b1; ifu.reg_target = 32'hFFFF_FFFC;
    tick("jr_top");
    clear_ctrl();
    tick("top");
    chk("top_p4", ifu.pc_plus4, 32'h0);
    tick("wrap");
    chk("wrap_pc", ifu.pc_out, 32'h0);
    chk("wrap_instr", ifu.instruction, 32'h2008_0005);

    // random controls
    for (int i = 0; i < 24; i++) begin
      clear_ctrl();
      ifu.stall = ($urandom_range(0, 4) == 0);
      ifu.flush = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0: begin ifu.jump_reg = 1'b1; ifu.reg_target = 32'($urandom_range(0, 4 * DEPTH + 16)); end
        1: begin ifu.jump = 1'b1; ifu.jump_target = 26'($urandom_range(0, DEPTH)); end
        2: begin ifu.branch_taken = 1'b1; ifu.branch_offset = 16'($urandom_range(0, 8)) - 16'd4; end
        default: ;
      endcase
      tick("rand");
    end

    // reset asserted mid-stall with a pending redirect
    clear_ctrl();
    ifu.stall = 1'b1; ifu.jump = 1'b1; ifu.jump_target = 26'h20;
    tick("pre_rst_stall");
    reset = 1'b1;
    tick("rst_mid");
    chk("rst_mid_valid", 32'(ifu.instr_valid), 32'h0);
    chk("rst_mid_pc", ifu.pc_out, 32'h0);
    reset = 1'b0;
    clear_ctrl();
    tick("post_rst");
    chk("post_rst_pc", ifu.pc_out, RST_PC);
    chk("post_rst_valid", 32'(ifu.instr_valid), 32'h1);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
